// File: rtl/sr_fifo_sched_pkg.sv
// sr_fifo_sched_pkg: shared operation encodings and constants for the FIFO
// access scheduler and its round-robin picker.
package sr_fifo_sched_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2
   } op_t;

   localparam logic LAST_WR = 1'b0;
   localparam logic LAST_RD = 1'b1;

   localparam int STAT_W = 16;

endpackage

// File: rtl/sr_rr_pick.sv
// sr_rr_pick: purely combinational round-robin picker. Scans the request
// vector starting at ptr and wrapping modulo NUM_REQ, returning the first
// set request as both a one-hot vector and an index.
module sr_rr_pick
   import sr_fifo_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   // First requester found at or after ptr (wrapping) wins
   always_comb begin
      any    = 1'b0;
      onehot = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
            any = 1'b1;
            onehot[(int'(ptr) + k) % NUM_REQ] = 1'b1;
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/sr_fifo_sched.sv
// sr_fifo_sched: access scheduler in front of a shared FIFO. Arbitrates
// NUM_REQ writers round-robin against a single reader, never issuing a
// write and a read in the same cycle, and alternating strictly when both
// are eligible. Optional per-requester write statistics are enabled by
// defining SR_FIFO_SCHED_STATS_EN.
module sr_fifo_sched
   import sr_fifo_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 2
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          rd_req,
   output logic                          rd_ack,
   output logic                          rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          fifo_write_enable,
   output logic [DATA_WIDTH-1:0]         fifo_write_data,
   output logic                          fifo_read_enable,
   input  logic [DATA_WIDTH-1:0]         fifo_read_data,
   input  logic                          fifo_full,
   input  logic                          fifo_empty
`ifdef SR_FIFO_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_cnt
`endif
);

   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_ptr_next;
   logic               last_op;
   logic               last_op_next;
   logic               rd_valid_q;
   logic               rd_valid_next;
   op_t                op;

   logic               pick_any;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               wr_elig;
   logic               rd_elig;

   sr_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign wr_elig = pick_any & ~fifo_full;
   assign rd_elig = rd_req & ~fifo_empty;

   // Scheduler state: round-robin pointer, last op issued, read-valid stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= '0;
         last_op    <= LAST_WR;
         rd_valid_q <= 1'b0;
      end else begin
         rr_ptr     <= rr_ptr_next;
         last_op    <= last_op_next;
         rd_valid_q <= rd_valid_next;
      end
   end

   // Pick this cycle's operation and the state it leaves behind
   always_comb begin
      op            = OP_IDLE;
      rr_ptr_next   = rr_ptr;
      last_op_next  = last_op;
      rd_valid_next = 1'b0;
      if (wr_elig && rd_elig) begin
         op = (last_op == LAST_WR) ? OP_RD : OP_WR;
      end else if (wr_elig) begin
         op = OP_WR;
      end else if (rd_elig) begin
         op = OP_RD;
      end
      case (op)
         OP_WR: begin
            rr_ptr_next  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            last_op_next = LAST_WR;
         end
         OP_RD: begin
            last_op_next  = LAST_RD;
            rd_valid_next = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Drive requester and FIFO side outputs; everything is held at zero in reset
   always_comb begin
      req_ready         = '0;
      grant_id          = '0;
      fifo_write_enable = 1'b0;
      fifo_write_data   = '0;
      fifo_read_enable  = 1'b0;
      rd_ack            = 1'b0;
      rd_valid          = 1'b0;
      rd_data           = '0;
      if (reset) begin
         case (op)
            OP_WR: begin
               req_ready         = pick_onehot;
               grant_id          = pick_idx;
               fifo_write_enable = 1'b1;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (pick_onehot[i]) begin
                     fifo_write_data = fifo_write_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
            OP_RD: begin
               rd_ack           = 1'b1;
               fifo_read_enable = 1'b1;
            end
            default: begin
            end
         endcase
         rd_valid = rd_valid_q;
         rd_data  = fifo_read_data;
      end
   end

`ifdef SR_FIFO_SCHED_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];

   // Per-requester saturating count of accepted writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (op == OP_WR && pick_onehot[i] && stat_q[i] != {STAT_W{1'b1}}) begin
               stat_q[i] <= stat_q[i] + STAT_W'(1);
            end
         end
      end
   end

   // Flatten the counters onto the statistics port
   always_comb begin
      stat_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
      end
   end
`endif

endmodule

// File: doc/sr_fifo_sched.md
Name: sr_fifo_sched

Overview:
Access scheduler for the shared single-port-style FIFO. It arbitrates NUM_REQ write requesters round-robin and one reader onto the FIFO's write_enable and read_enable. It never issues a write and a read in the same cycle, because the FIFO drops both in that case. It registers read-data-valid, and sits between the producer blocks and the FIFO instance.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DATA_WIDTH, 32, word width; must match the FIFO
IDX_W, 2, width of the requester index; must equal clog2(NUM_REQ)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid[i] & ready[i]
rd_req  in  1  reader wants one word (level)
rd_ack  out  1  read issued to FIFO this cycle
rd_valid  out  1  rd_data is valid (one cycle after rd_ack)
rd_data  out  DATA_WIDTH  word returned to the reader
grant_id  out  IDX_W  index of the requester accepted this cycle (0 when none)
fifo_write_enable  out  1  to FIFO write_enable
fifo_write_data  out  DATA_WIDTH  to FIFO write_data
fifo_read_enable  out  1  to FIFO read_enable
fifo_read_data  in  DATA_WIDTH  from FIFO read_data
fifo_full  in  1  from FIFO full
fifo_empty  in  1  from FIFO empty

Behaviour:
- State: rr_ptr[IDX_W] (highest-priority requester), last_op (0 = write, 1 = read), rd_valid_q.
- Reset (reset low, async): rr_ptr=0, last_op=0, rd_valid_q=0. All outputs are combinationally forced to 0 while reset is low.
- wr_elig = |req_valid & !fifo_full. rd_elig = rd_req & !fifo_empty.
- Op select (combinational):
  - Only wr_elig: WRITE.
  - Only rd_elig: READ.
  - Both: READ if last_op==0, else WRITE (strict alternation).
  - Neither: IDLE.
- WRITE:
  - Winner = first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready = onehot(winner); grant_id = winner; fifo_write_enable = 1; fifo_write_data = req_data[winner].
  - Edge: rr_ptr <= (winner+1) mod NUM_REQ; last_op <= 0.
- READ:
  - rd_ack = 1; fifo_read_enable = 1.
  - Edge: last_op <= 1; rd_valid_q <= 1.
- IDLE: all enables 0, req_ready = 0, rd_valid_q <= 0; rr_ptr and last_op hold.
- rd_valid = rd_valid_q; rd_data = fifo_read_data. Latency: rd_ack in cycle k gives rd_valid in cycle k+1.
- rd_valid_q <= 0 on any non-READ cycle. Back-to-back reads give continuous rd_valid.
- Zero-latency issue: ready depends on valid and the flags, never the reverse. Requesters must not gate valid on ready.
- Full: the FIFO's full updates on the accepting edge, so the next cycle sees full=1 and issues no write. Never write while fifo_full=1.
- Empty: same rule for reads. rd_req held while empty gives rd_ack=0 indefinitely.
- rr_ptr and last_op change only on an actual transfer; requests withdrawn mid-cycle have no effect.
- At no time are fifo_write_enable and fifo_read_enable both 1.
- Reset mid-operation: an in-flight rd_valid_q is cleared and no pending word is reported. The FIFO shares the same reset.

Optional Feature:
SR_FIFO_SCHED_STATS_EN:
- Defined: adds output stat_cnt[NUM_REQ*16]. Per-requester 16-bit saturating counters increment on each accepted write, saturate at 16'hFFFF, and reset to 0.
- Not defined: no port, no counters; behaviour is otherwise identical.

Decomposition:
- Package/header sr_fifo_sched_pkg holds:
  - OP_IDLE=2'd0, OP_WR=2'd1, OP_RD=2'd2
  - LAST_WR=1'b0, LAST_RD=1'b1
  - STAT_W=16
- Sub-module sr_rr_pick: purely combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr[IDX_W].
  - Outputs: any, onehot[NUM_REQ], idx[IDX_W].
  - Instantiated once.

Test Plan:
- Reset, then req_valid=4'b1111, rd_req=0, fifo empty: grants in order 0,1,2,3,0,... one per cycle, until fifo_full=1; req_ready=0 thereafter.
- req_valid=4'b1010 with rr_ptr=0: grant 1 then 3 then 1; data 32'hA5A5_0001 / 32'hA5A5_0003 appear on fifo_write_data in the grant cycle.
- rd_req=1 with 3 words queued, no writers: rd_ack on 3 consecutive cycles, rd_valid in the following 3 cycles, then rd_ack=0 once fifo_empty=1.
- Writers and rd_req both continuously active, FIFO non-empty and not full: ops alternate R,W,R,W starting with READ after reset; the enables are never both high.
- Assert reset for 1 cycle in the cycle after an rd_ack: rd_valid=0 immediately, rr_ptr=0, and the next grant goes to requester 0.
- With SR_FIFO_SCHED_STATS_EN: 5 writes from requester 2 give stat_cnt slice 2 == 5, other slices 0. With the counter preloaded via 65540 writes, the slice saturates at 16'hFFFF.
